ibex_rf_wport_arb: RTL and testbench

IBEX_RF_WPORT_ARB -- requirements
Module: ibex_rf_wport_arb

---
 rtl/ibex_rf_wport_arb.sv | 165 ++++++++++++++++
 tb/tb_ibex_rf_wport_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_wport_arb.sv
// Register-file write-port arbiter.
// The writeback stage owns the single RF write port and wins every cycle it
// writes. A secondary multi-cycle unit posts its writes into a 2-entry FIFO
// that drains whenever the port is free. If writeback keeps the port busy for
// MaxStarve consecutive cycles while an entry is waiting, writeback is stalled
// for one cycle so the FIFO head can retire.
module ibex_rf_wport_arb #(
  parameter int unsigned MaxStarve = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  // writeback stage
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  output logic        wb_stall_o,

  // secondary requester
  input  logic        acc_valid_i,
  input  logic [4:0]  acc_waddr_i,
  input  logic [31:0] acc_wdata_i,
  output logic        acc_ready_o,

  // ID-stage hazard lookup
  input  logic [4:0]  hazard_raddr_a_i,
  input  logic [4:0]  hazard_raddr_b_i,
  output logic        hazard_o,
  output logic        pending_o,

  // register-file write port
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,

  output logic        err_o
);

  localparam int unsigned Depth     = 2;
  localparam logic [3:0]  StarveMax = 4'(MaxStarve);

  // Catch illegal parameterisation at elaboration time.
  if (MaxStarve < 1 || MaxStarve > 15) begin : g_param_check
    $error("ibex_rf_wport_arb: MaxStarve must be in 1..15");
  end

  // FIFO state
  logic [1:0]             count_q, count_d;
  logic                   rptr_q, rptr_d;
  logic                   wptr_q, wptr_d;
  logic [Depth-1:0][4:0]  addr_q;
  logic [Depth-1:0][31:0] data_q;
  logic [Depth-1:0]       slot_vld;

  // starvation tracking
  logic [3:0]             starve_q, starve_d;

  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   wb_go;

  // Handshake and arbitration decisions. Ready and stall depend only on
  // registered state, so the secondary unit and the writeback stage never see
  // a combinational loop through the arbiter.
  assign fifo_empty  = (count_q == 2'd0);
  assign acc_ready_o = (count_q < 2'(Depth));
  assign pending_o   = ~fifo_empty;
  assign wb_stall_o  = (starve_q == StarveMax);

  // Writes to x0 are accepted so the requester can retire them, but nothing
  // is buffered: the RF ignores x0 anyway.
  assign push  = acc_valid_i & acc_ready_o & (acc_waddr_i != 5'd0);

  // Writeback wins unless it is being stalled; otherwise the head drains.
  // A stall implies the FIFO is non-empty, so the head always retires then.
  assign wb_go = wb_we_i & ~wb_stall_o;
  assign pop   = ~wb_go & ~fifo_empty;

  // Writeback asserting a write while stalled is a protocol violation; its
  // write is dropped in favour of the FIFO head.
  assign err_o = wb_we_i & wb_stall_o;

  // Write-port mux: writeback pass-through, else FIFO head, else idle zeros.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (wb_go) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_waddr_i;
      rf_wdata_o = wb_wdata_i;
    end else if (pop) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = addr_q[rptr_q];
      rf_wdata_o = data_q[rptr_q];
    end
  end

  // FIFO pointer/occupancy next state; push and pop together keep the count.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (push) wptr_d = ~wptr_q;
    if (pop)  rptr_d = ~rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Starve counter: counts cycles the head waits, saturating at MaxStarve;
  // any pop or an empty FIFO restarts it.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = 4'd0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      count_q  <= count_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      starve_q <= starve_d;
    end
  end

  // FIFO storage; only the slot at the write pointer is updated on a push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (push) begin
      addr_q[wptr_q] <= acc_waddr_i;
      data_q[wptr_q] <= acc_wdata_i;
    end
  end

  // Hazard lookup against every occupied slot. A full FIFO has both slots
  // valid; a single entry sits at the read pointer. Reads of x0 never match.
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      slot_vld[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (rptr_q == 1'(i)));
      if (slot_vld[i] &&
          (((hazard_raddr_a_i != 5'd0) && (addr_q[i] == hazard_raddr_a_i)) ||
           ((hazard_raddr_b_i != 5'd0) && (addr_q[i] == hazard_raddr_b_i)))) begin
        hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_wport_arb.sv
// Bench for ibex_rf_wport_arb: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_ibex_rf_wport_arb;

  localparam int MS = 4;

  logic        clk_i, rst_ni;
  logic        wb_we_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        wb_stall_o;
  logic        acc_valid_i;
  logic [4:0]  acc_waddr_i;
  logic [31:0] acc_wdata_i;
  logic        acc_ready_o;
  logic [4:0]  hazard_raddr_a_i, hazard_raddr_b_i;
  logic        hazard_o, pending_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        err_o;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [42:0] obs, ev;
  assign obs = {acc_ready_o, wb_stall_o, hazard_o, pending_o, err_o,
                rf_we_o, rf_waddr_o, rf_wdata_o};

  ibex_rf_wport_arb #(.MaxStarve(MS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .wb_stall_o(wb_stall_o),
    .acc_valid_i(acc_valid_i), .acc_waddr_i(acc_waddr_i), .acc_wdata_i(acc_wdata_i),
    .acc_ready_o(acc_ready_o),
    .hazard_raddr_a_i(hazard_raddr_a_i), .hazard_raddr_b_i(hazard_raddr_b_i),
    .hazard_o(hazard_o), .pending_o(pending_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // expected output vector: {ready, stall, hazard, pending, err, we, addr, data}
  function automatic logic [42:0] exp_v(input logic rdy, input logic st, input logic hz,
                                        input logic pd, input logic er, input logic we,
                                        input logic [4:0] a, input logic [31:0] d);
    return {rdy, st, hz, pd, er, we, a, d};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wb_we_i = 1'b0; wb_waddr_i = 5'd0; wb_wdata_i = 32'd0;
    acc_valid_i = 1'b0; acc_waddr_i = 5'd0; acc_wdata_i = 32'd0;
    hazard_raddr_a_i = 5'd0; hazard_raddr_b_i = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    wb_we_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = 32'h0000_1234;
    #1;
    ev = exp_v(1, 0, 0, 0, 0, 1, 5'd3, 32'h0000_1234);
    tot_cnt++; if (obs !== ev) $display("FAIL reset_pass obs=%h exp=%h", obs, ev); else pass_cnt++;
    wb_we_i = 1'b0;
    #1;
    ev = exp_v(1, 0, 0, 0, 0, 0, 5'd0, 32'd0);
    tot_cnt++; if (obs !== ev) $display("FAIL reset_idle obs=%h exp=%h", obs, ev); else pass_cnt++;
    idle();
    step(); step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_basic();
    idle();
    acc_valid_i = 1'b1; acc_waddr_i = 5'd5; acc_wdata_i = 32'hA5A5_A5A5;
    #1;
    ev = exp_v(1, 0, 0, 0, 0, 0, 5'd0, 32'd0);
    tot_cnt++; if (obs !== ev) $display("FAIL basic_c0 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step(); idle(); #1;
    ev = exp_v(1, 0, 0, 1, 0, 1, 5'd5, 32'hA5A5_A5A5);
    tot_cnt++; if (obs !== ev) $display("FAIL basic_c1 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step(); #1;
    ev = exp_v(1, 0, 0, 0, 0, 0, 5'd0, 32'd0);
    tot_cnt++; if (obs !== ev) $display("FAIL basic_c2 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
  endtask

  task automatic test_starve();
    idle();
    wb_we_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = 32'hCAFE_0003;
    acc_valid_i = 1'b1; acc_waddr_i = 5'd7; acc_wdata_i = 32'h7777_7777;
    #1;
    ev = exp_v(1, 0, 0, 0, 0, 1, 5'd3, 32'hCAFE_0003);
    tot_cnt++; if (obs !== ev) $display("FAIL starve_c0 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    acc_valid_i = 1'b0;
    for (int c = 1; c <= MS; c++) begin
      #1;
      ev = exp_v(1, 0, 0, 1, 0, 1, 5'd3, 32'hCAFE_0003);
      tot_cnt++; if (obs !== ev) $display("FAIL starve_wait%0d obs=%h exp=%h", c, obs, ev); else pass_cnt++;
      step();
    end
    #1;
    ev = exp_v(1, 1, 0, 1, 1, 1, 5'd7, 32'h7777_7777);
    tot_cnt++; if (obs !== ev) $display("FAIL starve_stall obs=%h exp=%h", obs, ev); else pass_cnt++;
    step(); #1;
    ev = exp_v(1, 0, 0, 0, 0, 1, 5'd3, 32'hCAFE_0003);
    tot_cnt++; if (obs !== ev) $display("FAIL starve_after obs=%h exp=%h", obs, ev); else pass_cnt++;
    step(); idle();
  endtask

  task automatic test_full();
    idle();
    wb_we_i = 1'b1; wb_waddr_i = 5'd4; wb_wdata_i = 32'h44;
    acc_valid_i = 1'b1; acc_waddr_i = 5'd1; acc_wdata_i = 32'h11;
    #1;
    ev = exp_v(1, 0, 0, 0, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL full_c0 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    acc_waddr_i = 5'd2; acc_wdata_i = 32'h22; #1;
    ev = exp_v(1, 0, 0, 1, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL full_c1 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    acc_waddr_i = 5'd3; acc_wdata_i = 32'h33; #1;
    ev = exp_v(0, 0, 0, 1, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL full_notready obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    wb_we_i = 1'b0; wb_waddr_i = 5'd0; wb_wdata_i = 32'd0; #1;
    ev = exp_v(0, 0, 0, 1, 0, 1, 5'd1, 32'h11);
    tot_cnt++; if (obs !== ev) $display("FAIL full_pop1 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step(); #1;
    ev = exp_v(1, 0, 0, 1, 0, 1, 5'd2, 32'h22);
    tot_cnt++; if (obs !== ev) $display("FAIL full_pop2 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    acc_valid_i = 1'b0; #1;
    ev = exp_v(1, 0, 0, 1, 0, 1, 5'd3, 32'h33);
    tot_cnt++; if (obs !== ev) $display("FAIL full_pop3 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step(); #1;
    ev = exp_v(1, 0, 0, 0, 0, 0, 5'd0, 32'd0);
    tot_cnt++; if (obs !== ev) $display("FAIL full_drained obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
  endtask

  task automatic test_x0();
    idle();
    acc_valid_i = 1'b1; acc_waddr_i = 5'd0; acc_wdata_i = 32'hFFFF_FFFF;
    #1;
    ev = exp_v(1, 0, 0, 0, 0, 0, 5'd0, 32'd0);
    tot_cnt++; if (obs !== ev) $display("FAIL x0_c0 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step(); idle();
    for (int c = 1; c <= 2; c++) begin
      #1;
      tot_cnt++; if (obs !== ev) $display("FAIL x0_c%0d obs=%h exp=%h", c, obs, ev); else pass_cnt++;
      step();
    end
  endtask

  task automatic test_hazard_err();
    idle();
    wb_we_i = 1'b1; wb_waddr_i = 5'd4; wb_wdata_i = 32'h44;
    acc_valid_i = 1'b1; acc_waddr_i = 5'd9; acc_wdata_i = 32'h99;
    hazard_raddr_b_i = 5'd9;
    #1;
    ev = exp_v(1, 0, 0, 0, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL haz_notyet obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    acc_valid_i = 1'b0; #1;
    ev = exp_v(1, 0, 1, 1, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL haz_b9 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    hazard_raddr_b_i = 5'd3; #1;
    ev = exp_v(1, 0, 0, 1, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL haz_b3 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    hazard_raddr_a_i = 5'd9; hazard_raddr_b_i = 5'd0; #1;
    ev = exp_v(1, 0, 1, 1, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL haz_a9 obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    hazard_raddr_a_i = 5'd0; #1;
    ev = exp_v(1, 0, 0, 1, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL haz_zero obs=%h exp=%h", obs, ev); else pass_cnt++;
    step();
    hazard_raddr_b_i = 5'd9; #1;
    ev = exp_v(1, 1, 1, 1, 1, 1, 5'd9, 32'h99);
    tot_cnt++; if (obs !== ev) $display("FAIL err_stall obs=%h exp=%h", obs, ev); else pass_cnt++;
    step(); #1;
    ev = exp_v(1, 0, 0, 0, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL err_after obs=%h exp=%h", obs, ev); else pass_cnt++;
    step(); idle();
  endtask

  task automatic test_reset_mid();
    idle();
    wb_we_i = 1'b1; wb_waddr_i = 5'd4; wb_wdata_i = 32'h44;
    acc_valid_i = 1'b1; acc_waddr_i = 5'd10; acc_wdata_i = 32'hAAAA;
    step();
    acc_waddr_i = 5'd11; acc_wdata_i = 32'hBBBB;
    step();
    acc_valid_i = 1'b0; #1;
    ev = exp_v(0, 0, 0, 1, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL rstmid_full obs=%h exp=%h", obs, ev); else pass_cnt++;
    rst_ni = 1'b0; #1;
    ev = exp_v(1, 0, 0, 0, 0, 1, 5'd4, 32'h44);
    tot_cnt++; if (obs !== ev) $display("FAIL rstmid_async obs=%h exp=%h", obs, ev); else pass_cnt++;
    idle();
    step(); step();
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      ev = exp_v(1, 0, 0, 0, 0, 0, 5'd0, 32'd0);
      tot_cnt++; if (obs !== ev) $display("FAIL rstmid_rel%0d obs=%h exp=%h", c, obs, ev); else pass_cnt++;
      step();
    end
  endtask

  // Randomized traffic against a queue model of the arbiter's rules.
  task automatic test_random();
    logic [36:0] mq[$];
    int          blk = 0;
    int          nerr = 0;
    logic        stall, rdy, wbgo, popm, hz;
    logic [36:0] wr;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      stall = (blk == MS);
      acc_valid_i      = 1'($urandom_range(0, 1));
      acc_waddr_i      = 5'($urandom_range(0, 7));
      acc_wdata_i      = $urandom;
      wb_waddr_i       = 5'($urandom);
      wb_wdata_i       = $urandom;
      hazard_raddr_a_i = 5'($urandom_range(0, 7));
      hazard_raddr_b_i = 5'($urandom_range(0, 7));
      // a well-behaved writeback stage, with occasional protocol violations
      if ($urandom_range(0, 15) == 0) wb_we_i = 1'b1;
      else wb_we_i = stall ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      rdy  = (mq.size() < 2);
      wbgo = wb_we_i && !stall;
      popm = !wbgo && (mq.size() > 0);
      hz   = 1'b0;
      foreach (mq[k]) begin
        if ((hazard_raddr_a_i != 0 && mq[k][36:32] == hazard_raddr_a_i) ||
            (hazard_raddr_b_i != 0 && mq[k][36:32] == hazard_raddr_b_i)) hz = 1'b1;
      end
      if (wbgo)      wr = {wb_waddr_i, wb_wdata_i};
      else if (popm) wr = mq[0];
      else           wr = '0;
      ev = {rdy, stall, hz, (mq.size() != 0), (wb_we_i && stall), (wbgo || popm), wr};
      tot_cnt++;
      if (obs !== ev) begin
        nerr++;
        if (nerr <= 10) $display("FAIL rand_cyc%0d obs=%h exp=%h", cyc, obs, ev);
      end else pass_cnt++;
      // advance the model across the clock edge
      if (popm) begin
        void'(mq.pop_front());
        blk = 0;
      end else if (mq.size() > 0) begin
        blk = (blk < MS) ? blk + 1 : MS;
      end else begin
        blk = 0;
      end
      if (acc_valid_i && rdy && acc_waddr_i != 0) mq.push_back({acc_waddr_i, acc_wdata_i});
      step();
    end
    idle();
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_starve();
    test_full();
    test_x0();
    test_hazard_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout passed=%0d total=%0d", pass_cnt, tot_cnt);
    $fatal(1);
  end

endmodule
